// File: rtl/hotspot_pkg.sv
// Shared Q10.22 format constants, stencil field offsets and output saturation for the HotSpot kernel.
package hotspot_pkg;
   localparam int INT_WIDTH   = 10;
   localparam int FLOAT_WIDTH = 22;
   localparam int DATA_WIDTH  = INT_WIDTH + FLOAT_WIDTH;
   localparam int POWER_SHIFT = 9;

   localparam int STC_C = 0;
   localparam int STC_N = DATA_WIDTH;
   localparam int STC_S = 2 * DATA_WIDTH;
   localparam int STC_E = 3 * DATA_WIDTH;
   localparam int STC_W = 4 * DATA_WIDTH;

   localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1;
   localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (DATA_WIDTH - 1));

   function automatic logic signed [DATA_WIDTH-1:0] sat32(input logic signed [63:0] v);
      logic signed [DATA_WIDTH-1:0] r;
      if (v > SAT_MAX)
         r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else if (v < SAT_MIN)
         r = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else
         r = v[DATA_WIDTH-1:0];
      return r;
   endfunction
endpackage

// File: rtl/hotspot_compute_if.sv
// Stream bundle of the HotSpot kernel: stencil and power inputs, result output.
interface hotspot_compute_if import hotspot_pkg::*; #(parameter int DW = DATA_WIDTH) ();
   logic [5*DW-1:0] s_axis_temp_data;
   logic            s_axis_temp_valid;
   logic            s_axis_temp_ready;
   logic [DW-1:0]   s_axis_power_data;
   logic            s_axis_power_valid;
   logic            s_axis_power_ready;
   logic [DW-1:0]   m_axis_result_data;
   logic            m_axis_result_valid;
   logic            m_axis_result_ready;
   logic            m_axis_result_last;

   modport slave (
      input  s_axis_temp_data, s_axis_temp_valid, s_axis_power_data, s_axis_power_valid,
             m_axis_result_ready,
      output s_axis_temp_ready, s_axis_power_ready,
             m_axis_result_data, m_axis_result_valid, m_axis_result_last
   );

   modport master (
      output s_axis_temp_data, s_axis_temp_valid, s_axis_power_data, s_axis_power_valid,
             m_axis_result_ready,
      input  s_axis_temp_ready, s_axis_power_ready,
             m_axis_result_data, m_axis_result_valid, m_axis_result_last
   );
endinterface

// File: rtl/hotspot_compute_axis_join2.sv
// Two-stream valid/ready join: a beat exists only when both sides are valid.
module axis_join2 (
   input  logic a_valid_i,
   input  logic b_valid_i,
   input  logic en_i,
   output logic a_ready_o,
   output logic b_ready_o,
   output logic valid_o
);
   // Ready is raised only for a complete pair, so a lone valid sees no ready on either side.
   assign valid_o   = a_valid_i & b_valid_i;
   assign a_ready_o = en_i & valid_o;
   assign b_ready_o = en_i & valid_o;
endmodule

// File: rtl/hotspot_compute.sv
// HotSpot per-cell update: joins stencil and power beats, 4-stage stall-able Q10.22 pipeline.
module hotspot_compute import hotspot_pkg::*; #(
   parameter int SIZE = 512
) (
   input  logic                         aclk,
   input  logic                         axi_resetn,
   input  logic signed [DATA_WIDTH-1:0] cfg_rx,
   input  logic signed [DATA_WIDTH-1:0] cfg_ry,
   input  logic signed [DATA_WIDTH-1:0] cfg_rz,
   input  logic signed [DATA_WIDTH-1:0] cfg_sdc,
   input  logic signed [DATA_WIDTH-1:0] cfg_amb,
   hotspot_compute_if.slave             bus
);
   localparam int D1W   = DATA_WIDTH + 2;
   localparam int PW    = 2 * DATA_WIDTH + 2;
   localparam int SW    = PW + 2;
   localparam int MW    = SW + DATA_WIDTH;
   localparam int RW    = MW - 2 * FLOAT_WIDTH + 1;
   localparam int FRAME = SIZE * SIZE;
   localparam int CW    = $clog2(FRAME + 1);

   logic en, en_acc, join_valid, out_hs, cnt_last;
   logic v1_q, v2_q, v3_q, v4_q;
   logic [CW-1:0] cnt_q, cnt_d;

   logic signed [DATA_WIDTH-1:0] c_in, n_in, s_in, e_in, w_in, p_d;
   logic signed [D1W-1:0] dx_d, dy_d, dz_d, dx_q, dy_q, dz_q;
   logic signed [DATA_WIDTH-1:0] c1_q, p1_q, c2_q, p2_q, c3_q;
   logic signed [PW-1:0]  px_d, py_d, pz_d, px_q, py_q, pz_q;
   logic signed [SW-1:0]  sum_d;
   logic signed [MW-1:0]  prod_d, prod_q;
   logic signed [RW-1:0]  res_d;
   logic [DATA_WIDTH-1:0] data_d, data_q;

   assign en     = ~v4_q | bus.m_axis_result_ready;
   assign en_acc = en & axi_resetn;

   axis_join2 u_join (
      .a_valid_i (bus.s_axis_temp_valid),
      .b_valid_i (bus.s_axis_power_valid),
      .en_i      (en_acc),
      .a_ready_o (bus.s_axis_temp_ready),
      .b_ready_o (bus.s_axis_power_ready),
      .valid_o   (join_valid)
   );

   always_comb begin
      c_in   = $signed(bus.s_axis_temp_data[STC_C +: DATA_WIDTH]);
      n_in   = $signed(bus.s_axis_temp_data[STC_N +: DATA_WIDTH]);
      s_in   = $signed(bus.s_axis_temp_data[STC_S +: DATA_WIDTH]);
      e_in   = $signed(bus.s_axis_temp_data[STC_E +: DATA_WIDTH]);
      w_in   = $signed(bus.s_axis_temp_data[STC_W +: DATA_WIDTH]);
      p_d    = $signed(bus.s_axis_power_data) >>> POWER_SHIFT;
      dy_d   = D1W'(n_in) + D1W'(s_in) - D1W'(c_in) - D1W'(c_in);
      dx_d   = D1W'(e_in) + D1W'(w_in) - D1W'(c_in) - D1W'(c_in);
      dz_d   = D1W'(cfg_amb) - D1W'(c_in);
      px_d   = PW'(dx_q) * PW'(cfg_rx);
      py_d   = PW'(dy_q) * PW'(cfg_ry);
      pz_d   = PW'(dz_q) * PW'(cfg_rz);
      sum_d  = SW'(px_q) + SW'(py_q) + SW'(pz_q) + (SW'(p2_q) <<< FLOAT_WIDTH);
      prod_d = MW'(sum_d) * MW'(cfg_sdc);
      // Arithmetic shift of Q.66 down to Q.22 floors toward minus infinity.
      res_d  = RW'(c3_q) + RW'(prod_q >>> (2 * FLOAT_WIDTH));
      data_d = sat32(64'(res_d));
   end

   always_ff @(posedge aclk) begin
      if (en) begin
         c1_q   <= c_in;
         p1_q   <= p_d;
         dx_q   <= dx_d;
         dy_q   <= dy_d;
         dz_q   <= dz_d;
         c2_q   <= c1_q;
         p2_q   <= p1_q;
         px_q   <= px_d;
         py_q   <= py_d;
         pz_q   <= pz_d;
         c3_q   <= c2_q;
         prod_q <= prod_d;
      end
   end

   assign out_hs   = v4_q & bus.m_axis_result_ready;
   assign cnt_last = (cnt_q == CW'(FRAME - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (out_hs)
         cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge aclk) begin
      if (!axi_resetn) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         v3_q   <= 1'b0;
         v4_q   <= 1'b0;
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (en) begin
            v1_q   <= join_valid;
            v2_q   <= v1_q;
            v3_q   <= v2_q;
            v4_q   <= v3_q;
            data_q <= data_d;
         end
      end
   end

   assign bus.m_axis_result_valid = v4_q;
   assign bus.m_axis_result_data  = data_q;
   assign bus.m_axis_result_last  = v4_q & cnt_last;
endmodule

// File: tb/tb_hotspot_compute.sv
// Randomized bench for hotspot_compute against a wide-integer reference of the update rule.
module tb_hotspot_compute;
   localparam int SIZE  = 4;
   localparam int FRAME = SIZE * SIZE;

   logic aclk = 1'b0;
   logic axi_resetn = 1'b0;
   logic [31:0] cfg_rx, cfg_ry, cfg_rz, cfg_sdc, cfg_amb;

   hotspot_compute_if bus ();

   hotspot_compute #(.SIZE(SIZE)) dut (
      .aclk       (aclk),
      .axi_resetn (axi_resetn),
      .cfg_rx     (cfg_rx),
      .cfg_ry     (cfg_ry),
      .cfg_rz     (cfg_rz),
      .cfg_sdc    (cfg_sdc),
      .cfg_amb    (cfg_amb),
      .bus        (bus)
   );

   always #5 aclk = ~aclk;

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];
   int res_idx = 0;
   int n_res = 0;
   logic [31:0] last_out = '0;
   int rdy_mode = 0;
   int rcyc = 0;
   logic stall_prev = 1'b0;
   logic [31:0] data_prev = '0;
   logic last_prev = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Next temperature computed from the update rule with 128-bit integers.
   function automatic logic [31:0] ref_result(input logic [159:0] t, input logic [31:0] pw);
      logic signed [127:0] c, n, s, e, w, p, sum, prod, res;
      logic [31:0] r;
      c = $signed(t[31:0]);
      n = $signed(t[63:32]);
      s = $signed(t[95:64]);
      e = $signed(t[127:96]);
      w = $signed(t[159:128]);
      p = $signed(pw);
      p = p >>> 9;
      sum = (e + w - 2 * c) * $signed(cfg_rx) + (n + s - 2 * c) * $signed(cfg_ry)
          + ($signed(cfg_amb) - c) * $signed(cfg_rz) + p * 128'sd4194304;
      prod = sum * $signed(cfg_sdc);
      res = c + (prod >>> 44);
      if (res > 128'sd2147483647) r = 32'h7FFFFFFF;
      else if (res < -128'sd2147483648) r = 32'h80000000;
      else r = res[31:0];
      return r;
   endfunction

   initial begin
      logic [31:0] e;
      forever begin
         @(negedge aclk);
         if (axi_resetn) begin
            if (stall_prev) begin
               check_val("hold_valid", bus.m_axis_result_valid, 1);
               check_val("hold_data", bus.m_axis_result_data, data_prev);
               check_val("hold_last", bus.m_axis_result_last, last_prev);
            end
            check_val("ready_pair", bus.s_axis_temp_ready, bus.s_axis_power_ready);
            if (bus.m_axis_result_valid && bus.m_axis_result_ready) begin
               check_val("result_expected", 64'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check_val("data", bus.m_axis_result_data, e);
                  check_val("last", bus.m_axis_result_last, 64'((res_idx % FRAME) == FRAME - 1));
                  res_idx++;
                  n_res++;
                  last_out = bus.m_axis_result_data;
               end
            end
            if (bus.s_axis_temp_valid && bus.s_axis_temp_ready && bus.s_axis_power_valid)
               exp_q.push_back(ref_result(bus.s_axis_temp_data, bus.s_axis_power_data));
            stall_prev = bus.m_axis_result_valid & ~bus.m_axis_result_ready;
            data_prev  = bus.m_axis_result_data;
            last_prev  = bus.m_axis_result_last;
         end else begin
            stall_prev = 1'b0;
         end
      end
   end

   initial begin
      bus.m_axis_result_ready = 1'b0;
      forever begin
         @(posedge aclk);
         #1;
         if (rdy_mode == 0) bus.m_axis_result_ready = 1'b1;
         else begin
            rcyc++;
            bus.m_axis_result_ready = (rcyc >= 30 && rcyc < 40) ? 1'b0 : 1'($urandom_range(0, 1));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   // skew > 0: temp leads power by skew cycles; skew < 0: power leads temp.
   task automatic push_beat(input logic [159:0] t, input logic [31:0] p, input int skew);
      int k;
      bit done;
      bus.s_axis_temp_data   = t;
      bus.s_axis_power_data  = p;
      bus.s_axis_temp_valid  = (skew >= 0);
      bus.s_axis_power_valid = (skew <= 0);
      for (int i = 0; i < (skew < 0 ? -skew : skew); i++) begin
         @(negedge aclk);
         check_val("skew_temp_ready", bus.s_axis_temp_ready, 0);
         check_val("skew_power_ready", bus.s_axis_power_ready, 0);
         @(posedge aclk);
         #1;
      end
      bus.s_axis_temp_valid  = 1'b1;
      bus.s_axis_power_valid = 1'b1;
      k = 0;
      done = 1'b0;
      while (!done && k < 200) begin
         @(negedge aclk);
         done = bus.s_axis_temp_ready;
         @(posedge aclk);
         #1;
         k++;
      end
      check_val("accept_timeout", done, 1);
      bus.s_axis_temp_valid  = 1'b0;
      bus.s_axis_power_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 1000) begin
         @(negedge aclk);
         k++;
      end
      check_val("drain_timeout", exp_q.size(), 0);
      @(posedge aclk);
      #1;
   endtask

   task automatic do_reset();
      axi_resetn = 1'b0;
      exp_q.delete();
      res_idx = 0;
      bus.s_axis_temp_valid  = 1'b1;
      bus.s_axis_power_valid = 1'b1;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      check_val("rst_valid", bus.m_axis_result_valid, 0);
      check_val("rst_last", bus.m_axis_result_last, 0);
      check_val("rst_data", bus.m_axis_result_data, 0);
      check_val("rst_temp_ready", bus.s_axis_temp_ready, 0);
      check_val("rst_power_ready", bus.s_axis_power_ready, 0);
      @(posedge aclk);
      #1;
      bus.s_axis_temp_valid  = 1'b0;
      bus.s_axis_power_valid = 1'b0;
      axi_resetn = 1'b1;
      @(posedge aclk);
      #1;
   endtask

   function automatic logic [159:0] stc(input logic [31:0] c, n, s, e, w);
      return {w, e, s, n, c};
   endfunction

   function automatic logic [159:0] rnd_stc();
      return {$urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      int n0;
      bus.s_axis_temp_data   = '0;
      bus.s_axis_power_data  = '0;
      bus.s_axis_temp_valid  = 1'b0;
      bus.s_axis_power_valid = 1'b0;
      cfg_rx = 32'h00400000; cfg_ry = 32'h00400000; cfg_rz = 32'h00400000;
      cfg_sdc = 32'h00400000; cfg_amb = 32'h00400000;
      @(posedge aclk);
      #1;
      do_reset();

      // Uniform field with latency probe.
      push_beat(stc(32'h00400000, 32'h00400000, 32'h00400000, 32'h00400000, 32'h00400000), 32'h0, 0);
      for (int i = 1; i <= 4; i++) begin
         @(negedge aclk);
         check_val("latency_valid", bus.m_axis_result_valid, 64'(i == 4));
      end
      @(posedge aclk);
      #1;
      drain();
      check_val("uniform", last_out, 32'h00400000);

      // Diffusion into a cold cell.
      cfg_rz = 32'h0; cfg_sdc = 32'h00200000;
      push_beat(stc(32'h0, 32'h00400000, 32'h00400000, 32'h00400000, 32'h00400000), 32'h0, 0);
      drain();
      check_val("diffusion", last_out, 32'h00800000);

      // Saturation, both directions.
      cfg_rx = 32'h0; cfg_ry = 32'h0; cfg_rz = 32'hFFC00000; cfg_sdc = 32'h00400000; cfg_amb = 32'h0;
      push_beat(stc(32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000), 32'h0, 0);
      drain();
      check_val("sat_pos", last_out, 32'h7FFFFFFF);
      push_beat(stc(32'h80400000, 32'h80400000, 32'h80400000, 32'h80400000, 32'h80400000), 32'h0, 0);
      drain();
      check_val("sat_neg", last_out, 32'h80000000);

      // Join skew: temp waits 3 cycles for power, then the reverse.
      cfg_rx = 32'h00100000; cfg_ry = 32'h00100000; cfg_rz = 32'h00100000;
      cfg_sdc = 32'h00080000; cfg_amb = 32'h01000000;
      n0 = n_res;
      push_beat(rnd_stc(), $urandom, 3);
      push_beat(rnd_stc(), $urandom, -3);
      drain();
      check_val("skew_count", n_res - n0, 2);

      // Backpressure on a 100-beat ramp, including a 10-cycle ready-low burst.
      rcyc = 0;
      rdy_mode = 1;
      n0 = n_res;
      for (int i = 0; i < 100; i++)
         push_beat(stc(32'(i) << 18, $urandom, $urandom, $urandom, $urandom), $urandom, 0);
      drain();
      check_val("bp_count", n_res - n0, 100);

      // Random coefficients and data with random skew and idle gaps.
      for (int r = 0; r < 3; r++) begin
         cfg_rx = $urandom; cfg_ry = $urandom; cfg_rz = $urandom;
         cfg_sdc = $urandom; cfg_amb = $urandom;
         rcyc = 0;
         for (int i = 0; i < 30; i++) begin
            push_beat(rnd_stc(), $urandom, $urandom_range(0, 4) - 2);
            repeat ($urandom_range(0, 2)) @(posedge aclk);
            #1;
         end
         drain();
      end
      rdy_mode = 0;

      // Frame/last over 40 back-to-back beats.
      do_reset();
      n0 = n_res;
      for (int i = 0; i < 40; i++) push_beat(rnd_stc(), $urandom, 0);
      drain();
      check_val("frame_count", n_res - n0, 40);

      // Reset in the middle of a stream.
      do_reset();
      for (int i = 0; i < 20; i++) push_beat(rnd_stc(), $urandom, 0);
      axi_resetn = 1'b0;
      exp_q.delete();
      res_idx = 0;
      @(posedge aclk);
      @(negedge aclk);
      check_val("midrst_valid", bus.m_axis_result_valid, 0);
      check_val("midrst_last", bus.m_axis_result_last, 0);
      @(posedge aclk);
      #1;
      axi_resetn = 1'b1;
      n0 = n_res;
      for (int i = 0; i < 20; i++) push_beat(rnd_stc(), $urandom, 0);
      drain();
      check_val("post_rst_count", n_res - n0, 20);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
